// File: rtl/cache_dirty_tracker_pkg.sv
// Shared geometry defaults and flush-scanner state type for the cache dirty tracker.
package cache_dirty_tracker_pkg;

    localparam int unsigned CACHE_WAYS = 2;
    localparam int unsigned CACHE_SETS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } flush_state_e;

endpackage

// File: rtl/cache_dirty_tracker_flush_fsm.sv
// Flush scanner: walks lines set-major/way-minor and offers each dirty one to writeback.
module cache_dirty_tracker_flush_fsm
    import cache_dirty_tracker_pkg::*;
#(
    parameter int unsigned WAYS = CACHE_WAYS,
    parameter int unsigned SETS = CACHE_SETS,
    localparam int unsigned WAY_W = $clog2(WAYS),
    localparam int unsigned SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush_req,
    input  logic             i_line_dirty,
    input  logic             i_wb_ready,
    output logic             o_busy,
    output logic             o_wb_valid,
    output logic [SET_W-1:0] o_wb_set,
    output logic [WAY_W-1:0] o_wb_way,
    output logic             o_flush_done,
    output logic             o_accept_c
);

    flush_state_e     r_state;
    flush_state_e     w_state_nxt;
    logic [SET_W-1:0] r_set;
    logic [SET_W-1:0] w_set_nxt;
    logic [SET_W-1:0] w_set_inc;
    logic [WAY_W-1:0] r_way;
    logic [WAY_W-1:0] w_way_nxt;
    logic [WAY_W-1:0] w_way_inc;
    logic             w_last;
    logic             r_busy;
    logic             r_wb_valid;
    logic             r_done;

    // Index successor: way wraps into the next set.
    always_comb begin
        w_last    = (r_set == SET_W'(SETS - 1)) && (r_way == WAY_W'(WAYS - 1));
        w_set_inc = r_set;
        w_way_inc = r_way + WAY_W'(1);
        if (r_way == WAY_W'(WAYS - 1)) begin
            w_way_inc = '0;
            w_set_inc = r_set + SET_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_nxt   = r_set;
        w_way_nxt   = r_way;
        o_accept_c  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_flush_req) begin
                    w_state_nxt = SCAN;
                    w_set_nxt   = '0;
                    w_way_nxt   = '0;
                end
            end
            SCAN: begin
                if (i_line_dirty) begin
                    w_state_nxt = OFFER;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_set_nxt = w_set_inc;
                    w_way_nxt = w_way_inc;
                end
            end
            OFFER: begin
                if (i_wb_ready) begin
                    o_accept_c = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SCAN;
                        w_set_nxt   = w_set_inc;
                        w_way_nxt   = w_way_inc;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_set      <= '0;
            r_way      <= '0;
            r_busy     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_set      <= w_set_nxt;
            r_way      <= w_way_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_wb_valid <= (w_state_nxt == OFFER);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    assign o_busy       = r_busy;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_set     = r_set;
    assign o_wb_way     = r_way;
    assign o_flush_done = r_done;

endmodule

// File: rtl/cache_dirty_tracker.sv
// Per-line dirty-bit store with live dirty count and an attached flush scanner.
module cache_dirty_tracker
    import cache_dirty_tracker_pkg::*;
#(
    parameter int unsigned WAYS  = CACHE_WAYS,
    parameter int unsigned SETS  = CACHE_SETS,
    parameter int unsigned CNT_W = $clog2(WAYS * SETS + 1),
    localparam int unsigned WAY_W = $clog2(WAYS),
    localparam int unsigned SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SET_W-1:0] set_sel,
    input  logic [WAY_W-1:0] way_sel,
    input  logic             mark_dirty,
    input  logic             clear,
    output logic             dirty_out,
    output logic [WAYS-1:0]  dirty_vec,
    output logic [CNT_W-1:0] dirty_count,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             wb_valid,
    output logic [SET_W-1:0] wb_set,
    output logic [WAY_W-1:0] wb_way,
    input  logic             wb_ready,
    output logic             flush_done
);

    logic [SETS-1:0][WAYS-1:0] r_dirty;
    logic [SETS-1:0][WAYS-1:0] w_dirty_nxt;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          w_up;
    logic [CNT_W-1:0]          w_dn;
    logic                      w_accept;
    logic                      w_scan_dirty;

    assign w_scan_dirty = r_dirty[wb_set][wb_way];

    cache_dirty_tracker_flush_fsm #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_flush_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_flush_req  (flush_req),
        .i_line_dirty (w_scan_dirty),
        .i_wb_ready   (wb_ready),
        .o_busy       (flush_busy),
        .o_wb_valid   (wb_valid),
        .o_wb_set     (wb_set),
        .o_wb_way     (wb_way),
        .o_flush_done (flush_done),
        .o_accept_c   (w_accept)
    );

    // Precedence: mark beats clear and accept; count follows real bit transitions.
    always_comb begin
        w_dirty_nxt = r_dirty;
        w_up        = '0;
        w_dn        = '0;
        if (w_accept)   w_dirty_nxt[wb_set][wb_way]   = 1'b0;
        if (clear)      w_dirty_nxt[set_sel][way_sel] = 1'b0;
        if (mark_dirty) w_dirty_nxt[set_sel][way_sel] = 1'b1;
        for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (w_dirty_nxt[SET_W'(s)][WAY_W'(w)] && !r_dirty[SET_W'(s)][WAY_W'(w)])
                    w_up = w_up + CNT_W'(1);
                if (!w_dirty_nxt[SET_W'(s)][WAY_W'(w)] && r_dirty[SET_W'(s)][WAY_W'(w)])
                    w_dn = w_dn + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty <= '0;
            r_count <= '0;
        end else begin
            r_dirty <= w_dirty_nxt;
            r_count <= r_count + w_up - w_dn;
        end
    end

    assign dirty_vec   = r_dirty[set_sel];
    assign dirty_out   = r_dirty[set_sel][way_sel];
    assign dirty_count = r_count;

endmodule
